// File: rtl/track_dpram_pkg.sv
// Shared constants for the floppy track buffer and its instantiators.
// TRACK_DPRAM_OUTREG_EN selects the two-cycle read latency build.
`timescale 1ns/1ps
package track_dpram_pkg;

  localparam int TRACK_ADDR_W = 14;
  localparam int TRACK_DATA_W = 8;

`ifdef TRACK_DPRAM_OUTREG_EN
  localparam int TRACK_RD_LATENCY = 2;
`else
  localparam int TRACK_RD_LATENCY = 1;
`endif

  function automatic int track_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/track_dpram_outreg.sv
// Asynchronously clearable data register; used as the read register of each
// port and, when TRACK_DPRAM_OUTREG_EN is defined, as the extra output stage.
`timescale 1ns/1ps
module track_dpram_outreg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/track_dpram.sv
// True dual-port track image RAM: port A serves the SD sector buffer, port B
// the drive emulation. Define TRACK_DPRAM_OUTREG_EN for 2-cycle read latency.
`timescale 1ns/1ps
module track_dpram
  import track_dpram_pkg::*;
#(
  parameter int DATA_WIDTH = TRACK_DATA_W,
  parameter int ADDR_WIDTH = TRACK_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = track_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;
  logic [DATA_WIDTH-1:0] w_q1_a;
  logic [DATA_WIDTH-1:0] w_q1_b;

  // NOTE: the array has no reset so it maps onto block RAM and keeps the
  // track image across a reset; writes proceed even while reset_n is low.
  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (wren_a) begin
      r_mem[address_a] <= data_a;
    end
    if (wren_b) begin
      r_mem[address_b] <= data_b;
    end
  end

  // The read register captures the pre-edge contents, giving read-first
  // behaviour on both the same port and the opposite port.
  assign w_rd_a = r_mem[address_a];
  assign w_rd_b = r_mem[address_b];

  track_dpram_outreg #(.DATA_WIDTH(DATA_WIDTH)) u_rd_a (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_rd_a),
    .o_q     (w_q1_a)
  );

  track_dpram_outreg #(.DATA_WIDTH(DATA_WIDTH)) u_rd_b (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_rd_b),
    .o_q     (w_q1_b)
  );

`ifdef TRACK_DPRAM_OUTREG_EN
  track_dpram_outreg #(.DATA_WIDTH(DATA_WIDTH)) u_pipe_a (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_q1_a),
    .o_q     (q_a)
  );

  track_dpram_outreg #(.DATA_WIDTH(DATA_WIDTH)) u_pipe_b (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_q1_b),
    .o_q     (q_b)
  );
`else
  assign q_a = w_q1_a;
  assign q_b = w_q1_b;
`endif

endmodule

// File: tb/tb_track_dpram.sv
// Self-checking bench for track_dpram: directed vector table, reset sequence
// and a full-range sweep, all checked through a latency-aware scoreboard.
`timescale 1ns/1ps
module tb_track_dpram;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;
`ifdef TRACK_DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] address_a;
  logic          wren_a;
  logic [DW-1:0] data_a;
  logic [DW-1:0] q_a;
  logic [AW-1:0] address_b;
  logic          wren_b;
  logic [DW-1:0] data_b;
  logic [DW-1:0] q_b;

  track_dpram dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address_a (address_a),
    .wren_a    (wren_a),
    .data_a    (data_a),
    .q_a       (q_a),
    .address_b (address_b),
    .wren_b    (wren_b),
    .data_b    (data_b),
    .q_b       (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] aa;
    logic          awe;
    logic [DW-1:0] ad;
    logic [AW-1:0] ba;
    logic          bwe;
    logic [DW-1:0] bd;
    logic          ca;
    logic [DW-1:0] ea;
    logic          cb;
    logic [DW-1:0] eb;
  } vec_t;

  typedef struct {
    int            due;
    logic          ca;
    logic [DW-1:0] ea;
    logic          cb;
    logic [DW-1:0] eb;
    string         nm;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] m [DEPTH];
  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            ecnt = 0;
  vec_t          vecs [14];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; expectations are due LAT-1 edges after this one.
  task automatic step(input logic [AW-1:0] aa, input logic awe, input logic [DW-1:0] ad,
                      input logic [AW-1:0] ba, input logic bwe, input logic [DW-1:0] bd,
                      input logic ca, input logic [DW-1:0] ea,
                      input logic cb, input logic [DW-1:0] eb, input string nm);
    sb_t e;
    address_a = aa; wren_a = awe; data_a = ad;
    address_b = ba; wren_b = bwe; data_b = bd;
    @(posedge clk);
    ecnt++;
    if (awe) m[aa] = ad;
    if (bwe) m[ba] = bd;
    e.due = ecnt + LAT - 1; e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb; e.nm = nm;
    sb.push_back(e);
    #1;
    while (sb.size() > 0 && sb[0].due <= ecnt) begin
      e = sb.pop_front();
      if (e.ca) check({e.nm, "_q_a"}, q_a, e.ea);
      if (e.cb) check({e.nm, "_q_b"}, q_b, e.eb);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < LAT - 1; k++)
      step(address_a, 1'b0, '0, address_b, 1'b0, '0, 1'b0, '0, 1'b0, '0, "idle");
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[13:6];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    reset_n = 1'b0;
    address_a = '0; wren_a = 1'b0; data_a = '0;
    address_b = '0; wren_b = 1'b0; data_b = '0;

    //          aa        awe   ad     ba        bwe   bd     ca    ea     cb    eb
    vecs[0]  = '{14'h0010, 1'b1, 8'h5A, 14'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{14'h0123, 1'b1, 8'hC3, 14'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{14'h0010, 1'b0, 8'h00, 14'h0123, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'hC3};
    vecs[3]  = '{14'h3FFF, 1'b1, 8'h11, 14'h0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hC3};
    vecs[4]  = '{14'h3FFF, 1'b1, 8'h22, 14'h0010, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 8'h5A};
    vecs[5]  = '{14'h3FFF, 1'b0, 8'h00, 14'h3FFF, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[6]  = '{14'h0010, 1'b0, 8'h00, 14'h0200, 1'b1, 8'h44, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[7]  = '{14'h0200, 1'b1, 8'h33, 14'h0200, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 8'h44};
    vecs[8]  = '{14'h0200, 1'b0, 8'h00, 14'h0200, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 8'h33};
    vecs[9]  = '{14'h1000, 1'b1, 8'hAA, 14'h1000, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{14'h1000, 1'b0, 8'h00, 14'h1000, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 8'h55};
    vecs[11] = '{14'h0001, 1'b1, 8'h01, 14'h0002, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[12] = '{14'h0002, 1'b0, 8'h00, 14'h0001, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01};
    vecs[13] = '{14'h0010, 1'b0, 8'h00, 14'h3FFF, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h22};

    // Power-on reset: outputs held at zero across an edge and after release.
    #12;
    check("por_q_a", q_a, 8'h00);
    check("por_q_b", q_b, 8'h00);
    reset_n = 1'b1;
    #1;
    check("por_rel_q_a", q_a, 8'h00);
    check("por_rel_q_b", q_b, 8'h00);

    for (int i = 0; i < 14; i++)
      step(vecs[i].aa, vecs[i].awe, vecs[i].ad, vecs[i].ba, vecs[i].bwe, vecs[i].bd,
           vecs[i].ca, vecs[i].ea, vecs[i].cb, vecs[i].eb, $sformatf("vec%0d", i));
    drain();

    // Mid-run reset: q_a holds 0x5A, reset clears it between edges, a write
    // during reset still lands, and the array keeps its contents.
    #2;
    check("pre_rst_q_a", q_a, 8'h5A);
    reset_n = 1'b0;
    #1;
    check("in_rst_q_a", q_a, 8'h00);
    check("in_rst_q_b", q_b, 8'h00);
    step(14'h0020, 1'b1, 8'h77, 14'h0010, 1'b0, '0, 1'b0, '0, 1'b0, '0, "rst_wr");
    drain();
    check("rst_edge_q_a", q_a, 8'h00);
    check("rst_edge_q_b", q_b, 8'h00);
    #2;
    reset_n = 1'b1;
    #1;
    check("rel_q_a", q_a, 8'h00);
    check("rel_q_b", q_b, 8'h00);
    step(14'h0010, 1'b0, '0, 14'h0020, 1'b0, '0, 1'b1, 8'h5A, 1'b1, 8'h77, "post_rst");
    drain();

    // Full-range sweep: A fills, then B reads back while A overwrites the
    // opposite half of the array.
    for (int i = 0; i < DEPTH; i++)
      step(AW'(i), 1'b1, pat(AW'(i)), '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, "fill");
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] wa;
      wa = AW'(i + DEPTH / 2);
      step(wa, 1'b1, ~pat(wa), AW'(i), 1'b0, '0, 1'b0, '0, 1'b1, m[i],
           $sformatf("sweep_%04h", i));
    end
    drain();

    vec_cnt++;
    if (sb.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
